reg_bank8: RTL and testbench

REG_BANK8 -- requirements
Module: reg_bank8

---
 rtl/reg_bank8.sv | 91 +++++++++
 tb/tb_reg_bank8.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank8.sv
// Eight-entry register bank with two registered read ports and a sequenced clear.
// Optional macro REG_BANK8_BYPASS_EN forwards same-edge write data to the read ports.
module reg_bank8 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  input  logic [2:0]       raddr_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic             wr_en;
  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] rd_a, rd_b;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = 3'd0;
        end else begin
          wr_en = load;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the array is small flops, not a RAM, so it can and must reset to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= in;
    end
  end

`ifdef REG_BANK8_BYPASS_EN
  assign rd_a = (wr_en && waddr == raddr_a) ? in : regs[raddr_a];
  assign rd_b = (wr_en && waddr == raddr_b) ? in : regs[raddr_b];
`else
  assign rd_a = regs[raddr_a];
  assign rd_b = regs[raddr_b];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_a <= '0;
      out_b <= '0;
    end else begin
      out_a <= rd_a;
      out_b <= rd_b;
    end
  end

endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: directed scenarios plus randomized traffic
// compared against a countdown-based behavioural model of the bank.
module tb_reg_bank8;
  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [2:0]       waddr = '0;
  logic [WIDTH-1:0] in = '0;
  logic             clr = 1'b0;
  logic [2:0]       raddr_a = '0;
  logic [2:0]       raddr_b = '0;
  logic [WIDTH-1:0] out_a, out_b;
  logic             busy;

  reg_bank8 #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .load(load), .waddr(waddr), .in(in), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: array contents, expected outputs, cycles of clearing still to go.
  logic [WIDTH-1:0] m_mem [8];
  logic [WIDTH-1:0] m_a, m_b;
  int               m_clear_left;
  int               n_checks = 0;
  int               n_pass = 0;

`ifdef REG_BANK8_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_a = '0;
    m_b = '0;
    m_clear_left = 0;
  endfunction

  // Drive one cycle of inputs (called at a falling edge), apply the model at the
  // rising edge, and return at the next falling edge ready for sampling.
  task automatic step(input logic ld, input logic [2:0] wa, input logic [WIDTH-1:0] d,
                      input logic cl, input logic [2:0] ra, input logic [2:0] rb);
    logic [WIDTH-1:0] old [8];
    bit               wrote;
    load = ld; waddr = wa; in = d; clr = cl; raddr_a = ra; raddr_b = rb;
    @(posedge clock);
    for (int i = 0; i < 8; i++) old[i] = m_mem[i];
    wrote = 1'b0;
    if (m_clear_left > 0) begin
      m_mem[8 - m_clear_left] = '0;
      m_clear_left--;
    end else if (cl) begin
      m_clear_left = 8;
    end else if (ld) begin
      m_mem[wa] = d;
      wrote = 1'b1;
    end
    m_a = (BYPASS && wrote && wa == ra) ? d : old[ra];
    m_b = (BYPASS && wrote && wa == rb) ? d : old[rb];
    @(negedge clock);
    load = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 3'd4, 16'h1234, 1'b0, 3'd4, 3'd4);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd4, 3'd4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({busy, out_a, out_b} !== {1'b0, 16'h0, 16'h0}) begin
      $display("FAIL reset_immediate: busy=%b out_a=%h out_b=%h, want 0 0000 0000", busy, out_a, out_b);
    end else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i));
      n_checks++;
      if ({out_a, out_b} !== {16'h0, 16'h0}) begin
        $display("FAIL reset_read r%0d: out_a=%h out_b=%h, want 0000 0000", i, out_a, out_b);
      end else n_pass++;
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 3'd3, 16'h3333, 1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd0);
    n_checks++;
    if ({out_a, out_b} !== {16'h3333, 16'h0000}) begin
      $display("FAIL write_read: out_a=%h out_b=%h, want 3333 0000", out_a, out_b);
    end else n_pass++;
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd3);
    n_checks++;
    if ({out_a, out_b} !== {16'h3333, 16'h3333}) begin
      $display("FAIL same_raddr: out_a=%h out_b=%h, want 3333 3333", out_a, out_b);
    end else n_pass++;
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] want;
    want = BYPASS ? 16'h5555 : 16'h0000;
    step(1'b1, 3'd5, 16'h5555, 1'b0, 3'd5, 3'd3);
    n_checks++;
    if ({out_a, out_b} !== {want, 16'h3333}) begin
      $display("FAIL bypass: out_a=%h out_b=%h, want %h 3333", out_a, out_b, want);
    end else n_pass++;
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd5, 3'd5);
    n_checks++;
    if ({out_a, out_b} !== {16'h5555, 16'h5555}) begin
      $display("FAIL bypass_next: out_a=%h out_b=%h, want 5555 5555", out_a, out_b);
    end else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'(i * 16'h1111), 1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd7);
    busy_cycles = 0;
    for (int c = 0; c < 12 && busy === 1'b1; c++) begin
      busy_cycles++;
      n_checks++;
      if ({out_a, out_b} !== {m_a, m_b}) begin
        $display("FAIL clear_read cyc%0d: out_a=%h out_b=%h, want %h %h", c, out_a, out_b, m_a, m_b);
      end else n_pass++;
      if (c == 0) step(1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd2, 3'd7);
      else        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 3'd7);
    end
    n_checks++;
    if (busy_cycles !== 8) begin
      $display("FAIL clear_busy_len: got %0d cycles, want 8", busy_cycles);
    end else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(i));
      n_checks++;
      if ({out_a, out_b} !== {16'h0, 16'h0}) begin
        $display("FAIL clear_result r%0d: out_a=%h out_b=%h, want 0000 0000", i, out_a, out_b);
      end else n_pass++;
    end
  endtask

  task automatic test_collision();
    step(1'b1, 3'd1, 16'h0BAD, 1'b0, 3'd0, 3'd0);
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd1, 3'd1);
    // r1 is still intact one edge into the clear, so a dropped write shows here.
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd1);
    n_checks++;
    if ({busy, out_a} !== {1'b1, 16'h0BAD}) begin
      $display("FAIL collision_drop: busy=%b out_a=%h, want 1 0bad", busy, out_a);
    end else n_pass++;
    repeat (8) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd1);
    n_checks++;
    if ({busy, out_a} !== {1'b0, 16'h0000}) begin
      $display("FAIL collision_clear: busy=%b out_a=%h, want 0 0000", busy, out_a);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'($urandom), 1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
    repeat (3) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL midclear_busy: busy=%b, want 1", busy);
    end else n_pass++;
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({busy, out_a, out_b} !== {1'b0, 16'h0, 16'h0}) begin
      $display("FAIL midclear_reset: busy=%b out_a=%h out_b=%h, want 0 0000 0000", busy, out_a, out_b);
    end else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd0);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL midclear_idle: busy=%b, want 0", busy);
    end else n_pass++;
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 3'd2);
    n_checks++;
    if ({out_a, out_b} !== {16'h6666, 16'h0000}) begin
      $display("FAIL midclear_write: out_a=%h out_b=%h, want 6666 0000", out_a, out_b);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      step(1'($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 29) == 0), 3'($urandom), 3'($urandom));
      n_checks++;
      if ({busy, out_a, out_b} !== {m_clear_left > 0, m_a, m_b}) begin
        $display("FAIL random cyc%0d: busy=%b out_a=%h out_b=%h, want %b %h %h",
                 c, busy, out_a, out_b, m_clear_left > 0, m_a, m_b);
      end else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
